// File: rtl/obi_sbr_scratchpad_pkg.sv
// rtl/obi_sbr_scratchpad_pkg.sv - scratchpad address-map constants, demux index and range helper
package obi_sbr_scratchpad_pkg;

    localparam logic [31:0] ScratchpadBase    = 32'h2000_0000;
    localparam int unsigned ScratchpadWords   = 64;
    localparam logic [31:0] ScratchpadErrData = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        UserDemuxError      = 2'd0,
        UserDemuxRegs       = 2'd1,
        UserDemuxScratchpad = 2'd2
    } user_demux_idx_e;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    // Entry for user_addr_map / user_mgr_addr_map; end_addr is exclusive.
    localparam addr_rule_t ScratchpadRule = '{
        idx:        32'(UserDemuxScratchpad),
        start_addr: ScratchpadBase,
        end_addr:   ScratchpadBase + 32'(ScratchpadWords * 4)
    };

    function automatic logic addr_in_rule(input logic [31:0] addr, input addr_rule_t rule);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/obi_rsp_pipe.sv
// rtl/obi_rsp_pipe.sv - fixed-depth valid/err/data response shift register
module obi_rsp_pipe #(
    parameter int unsigned Depth = 1,
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_valid,
    input  logic             push_err,
    input  logic [DataW-1:0] push_data,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [DataW-1:0] rsp_data
);

    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] err_q;
    logic [DataW-1:0] data_q [Depth];

    // Payload only moves with a valid entry, so the last stage holds between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            if (push_valid) begin
                err_q[0]  <= push_err;
                data_q[0] <= push_data;
            end
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    err_q[i]  <= err_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = valid_q[Depth-1];
    assign rsp_err   = err_q[Depth-1];
    assign rsp_data  = data_q[Depth-1];

endmodule

// File: rtl/obi_sbr_scratchpad.sv
// rtl/obi_sbr_scratchpad.sv - OBI subordinate serving a flop-based word scratchpad
module obi_sbr_scratchpad
    import obi_sbr_scratchpad_pkg::*;
#(
    parameter int unsigned NumWords      = ScratchpadWords,
    parameter logic [31:0] BaseAddr      = ScratchpadBase,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned GntWaitCycles = 0,
    parameter logic [31:0] ErrData       = ScratchpadErrData
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        obi_sbr_req_i,
    input  logic        obi_sbr_we_i,
    input  logic [31:0] obi_sbr_addr_i,
    input  logic [31:0] obi_sbr_wdata_i,
    input  logic [3:0]  obi_sbr_be_i,
    output logic        obi_sbr_gnt_o,
    output logic        obi_sbr_rvalid_o,
    output logic [31:0] obi_sbr_rdata_o,
    output logic        obi_sbr_err_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam addr_rule_t MemRule = '{
        idx:        32'(UserDemuxScratchpad),
        start_addr: BaseAddr,
        end_addr:   BaseAddr + 32'(NumWords * 4)
    };

    logic [31:0]     mem_q [NumWords];
    logic            accept;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            new_err;
    logic [31:0]     new_data;

    assign accept   = obi_sbr_req_i && obi_sbr_gnt_o;
    assign in_range = addr_in_rule(obi_sbr_addr_i, MemRule);
    assign idx      = obi_sbr_addr_i[2 +: IdxW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && obi_sbr_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_sbr_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= obi_sbr_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at the accept edge, so an earlier-cycle write is already visible.
    always_comb begin
        new_err  = !in_range;
        new_data = '0;
        if (!in_range) begin
            new_data = ErrData;
        end else if (!obi_sbr_we_i) begin
            new_data = mem_q[idx];
        end
    end

    generate
        if (GntWaitCycles == 0) begin : g_no_wait
            assign obi_sbr_gnt_o = obi_sbr_req_i;
        end else begin : g_wait
            localparam logic [1:0] StIdle  = 2'd0;
            localparam logic [1:0] StWait  = 2'd1;
            localparam logic [1:0] StGrant = 2'd2;

            logic [1:0] state_q, state_d;
            logic [2:0] cnt_q, cnt_d;

            // GRANT behaves like IDLE for the next request, so a held req waits N cycles from the grant.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    StWait: begin
                        if (!obi_sbr_req_i) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                            if (cnt_d == 3'd0) begin
                                state_d = StGrant;
                            end
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        if (obi_sbr_req_i) begin
                            if (GntWaitCycles == 1) begin
                                state_d = StGrant;
                            end else begin
                                state_d = StWait;
                                cnt_d   = 3'(GntWaitCycles - 1);
                            end
                        end
                    end
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign obi_sbr_gnt_o = (state_q == StGrant);
        end
    endgenerate

    obi_rsp_pipe #(
        .Depth (ReadLatency),
        .DataW (32)
    ) u_rsp_pipe (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_valid (accept),
        .push_err   (new_err),
        .push_data  (new_data),
        .rsp_valid  (obi_sbr_rvalid_o),
        .rsp_err    (obi_sbr_err_o),
        .rsp_data   (obi_sbr_rdata_o)
    );

endmodule

// File: tb/tb_obi_sbr_scratchpad.sv
// tb/tb_obi_sbr_scratchpad.sv - self-checking bench for obi_sbr_scratchpad
module tb_obi_sbr_scratchpad;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] ERRD = 32'hBADCAB1E;

    logic clk = 1'b0;
    logic rst_n;

    logic        req_ab, we_ab;
    logic [31:0] addr_ab, wdata_ab;
    logic [3:0]  be_ab;
    logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    logic        req_c, we_c;
    logic [31:0] addr_c, wdata_c;
    logic [3:0]  be_c;
    logic        gnt_c, rvalid_c, err_c;
    logic [31:0] rdata_c;

    obi_sbr_scratchpad #(.NumWords(64), .BaseAddr(BASE), .ReadLatency(1), .GntWaitCycles(0), .ErrData(ERRD)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .obi_sbr_req_i(req_ab), .obi_sbr_we_i(we_ab), .obi_sbr_addr_i(addr_ab),
        .obi_sbr_wdata_i(wdata_ab), .obi_sbr_be_i(be_ab), .obi_sbr_gnt_o(gnt_a), .obi_sbr_rvalid_o(rvalid_a),
        .obi_sbr_rdata_o(rdata_a), .obi_sbr_err_o(err_a));

    obi_sbr_scratchpad #(.NumWords(64), .BaseAddr(BASE), .ReadLatency(3), .GntWaitCycles(0), .ErrData(ERRD)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .obi_sbr_req_i(req_ab), .obi_sbr_we_i(we_ab), .obi_sbr_addr_i(addr_ab),
        .obi_sbr_wdata_i(wdata_ab), .obi_sbr_be_i(be_ab), .obi_sbr_gnt_o(gnt_b), .obi_sbr_rvalid_o(rvalid_b),
        .obi_sbr_rdata_o(rdata_b), .obi_sbr_err_o(err_b));

    obi_sbr_scratchpad #(.NumWords(64), .BaseAddr(BASE), .ReadLatency(2), .GntWaitCycles(2), .ErrData(ERRD)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .obi_sbr_req_i(req_c), .obi_sbr_we_i(we_c), .obi_sbr_addr_i(addr_c),
        .obi_sbr_wdata_i(wdata_c), .obi_sbr_be_i(be_c), .obi_sbr_gnt_o(gnt_c), .obi_sbr_rvalid_o(rvalid_c),
        .obi_sbr_rdata_o(rdata_c), .obi_sbr_err_o(err_c));

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] mem_ab [64];
    logic [31:0] mem_c  [64];
    rsp_t        q_a[$], q_b[$], q_c[$];
    bit          c_active = 0;
    int          c_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd256);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            mem_ab[i] = '0;
            mem_c[i]  = '0;
        end
        q_a.delete();
        q_b.delete();
        q_c.delete();
        c_active = 0;
    endtask

    task automatic model_access(input bit use_c, input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, output logic err, output logic [31:0] d);
        int          idx;
        logic [31:0] cur;
        err = !in_rng(a);
        d   = ERRD;
        if (!err) begin
            idx = int'((a - BASE) >> 2);
            cur = use_c ? mem_c[idx] : mem_ab[idx];
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
                end
                if (use_c) mem_c[idx] = cur;
                else       mem_ab[idx] = cur;
                d = '0;
            end else begin
                d = cur;
            end
        end
    endtask

    task automatic chk_rsp(input string nm, input bit exp_v, input rsp_t h,
                           input logic v, input logic [31:0] d, input logic e);
        chk({nm, " rvalid"}, 32'(v), 32'(exp_v));
        if (exp_v) begin
            chk({nm, " rdata"}, d, h.data);
            chk({nm, " err"}, 32'(e), 32'(h.err));
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle compare against the transaction-level model.
    initial begin
        rsp_t        h;
        bit          ev;
        bit          exp_gc;
        logic        me;
        logic [31:0] md;
        clear_model();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_model();
                chk("rst gnt_a", 32'(gnt_a), 0);       chk("rst rvalid_a", 32'(rvalid_a), 0);
                chk("rst rdata_a", rdata_a, 0);          chk("rst err_a", 32'(err_a), 0);
                chk("rst gnt_b", 32'(gnt_b), 0);       chk("rst rvalid_b", 32'(rvalid_b), 0);
                chk("rst rdata_b", rdata_b, 0);          chk("rst err_b", 32'(err_b), 0);
                chk("rst gnt_c", 32'(gnt_c), 0);       chk("rst rvalid_c", 32'(rvalid_c), 0);
                chk("rst rdata_c", rdata_c, 0);          chk("rst err_c", 32'(err_c), 0);
            end else begin
                ev = (q_a.size() > 0) && (q_a[0].due == cyc);
                h  = ev ? q_a[0] : '{-1, 1'b0, 32'h0};
                chk_rsp("a", ev, h, rvalid_a, rdata_a, err_a);
                if (ev) void'(q_a.pop_front());
                ev = (q_b.size() > 0) && (q_b[0].due == cyc);
                h  = ev ? q_b[0] : '{-1, 1'b0, 32'h0};
                chk_rsp("b", ev, h, rvalid_b, rdata_b, err_b);
                if (ev) void'(q_b.pop_front());
                ev = (q_c.size() > 0) && (q_c[0].due == cyc);
                h  = ev ? q_c[0] : '{-1, 1'b0, 32'h0};
                chk_rsp("c", ev, h, rvalid_c, rdata_c, err_c);
                if (ev) void'(q_c.pop_front());

                chk("a gnt", 32'(gnt_a), 32'(req_ab));
                chk("b gnt", 32'(gnt_b), 32'(req_ab));

                // C grants 2 cycles after req is first seen high, then 2 cycles after each grant.
                if (!req_c) c_active = 0;
                else if (!c_active) begin
                    c_active = 1;
                    c_start  = cyc;
                end
                exp_gc = c_active && (cyc - c_start == 2);
                chk("c gnt", 32'(gnt_c), 32'(exp_gc));
                if (exp_gc) c_start = cyc;

                if (req_ab) begin
                    model_access(1'b0, we_ab, addr_ab, wdata_ab, be_ab, me, md);
                    q_a.push_back('{cyc + 1, me, md});
                    q_b.push_back('{cyc + 3, me, md});
                end
                if (exp_gc) begin
                    model_access(1'b1, we_c, addr_c, wdata_c, be_c, me, md);
                    q_c.push_back('{cyc + 2, me, md});
                end
            end
        end
    end

    task automatic drive_ab(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_ab = 1'b1; we_ab = we; addr_ab = a; wdata_ab = wd; be_ab = be;
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return BASE - 32'd4;
        if (r == 1) return BASE + 32'd256;
        if (r == 2) return $urandom;
        if (r < 9) return BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        return BASE + 32'($urandom_range(0, 63) * 4);
    endfunction

    task automatic rand_ab();
        repeat (300) begin
            if ($urandom_range(0, 3) != 0)
                drive_ab(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            else begin
                req_ab = 1'b0;
                step();
            end
        end
        req_ab = 1'b0;
    endtask

    task automatic rand_c();
        int n;
        int gap;
        repeat (90) begin
            req_c = 1'b1; we_c = 1'($urandom_range(0, 1)); addr_c = rand_addr();
            wdata_c = $urandom; be_c = 4'($urandom_range(0, 15));
            n = 0;
            while (!gnt_c && n < 20) begin
                step();
                n++;
            end
            if (n >= 20) chk("c gnt wait bound", 32'(n), 32'd0);
            step();
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                req_c = 1'b0;
                repeat (gap) step();
            end
        end
        req_c = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_ab = 0; we_ab = 0; addr_ab = 0; wdata_ab = 0; be_ab = 0;
        req_c = 0; we_c = 0; addr_c = 0; wdata_c = 0; be_c = 0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Test 1: read of reset memory, grant same cycle, response next cycle.
        req_ab = 1; we_ab = 0; addr_ab = BASE + 32'h10; be_ab = 4'hF;
        #1 chk("t1 gnt same cycle", 32'(gnt_a), 1);
        step();
        req_ab = 0;
        chk("t1 rvalid", 32'(rvalid_a), 1);
        chk("t1 rdata", rdata_a, 32'h0);
        chk("t1 err", 32'(err_a), 0);

        // Test 2: byte-lane merge then back-to-back read.
        drive_ab(1, BASE + 32'h4, 32'hDEADBEEF, 4'hF);
        drive_ab(1, BASE + 32'h4, 32'h000000AA, 4'h1);
        drive_ab(0, BASE + 32'h4, 32'h0, 4'hF);
        req_ab = 0;
        chk("t2 rdata", rdata_a, 32'hDEADBEAA);

        // Test 3: out-of-range read and write, memory untouched.
        drive_ab(0, BASE + 32'd256, 32'h0, 4'hF);
        chk("t3 rd err", 32'(err_a), 1);
        chk("t3 rd rdata", rdata_a, 32'hBADCAB1E);
        drive_ab(1, BASE - 32'd4, 32'h12345678, 4'hF);
        chk("t3 wr err", 32'(err_a), 1);
        chk("t3 wr rdata", rdata_a, 32'hBADCAB1E);
        drive_ab(0, BASE, 32'h0, 4'hF);
        req_ab = 0;
        chk("t3 word0", rdata_a, 32'h0);
        chk("t3 word0 err", 32'(err_a), 0);

        // Test 4: latency-3 ordering on dut_b.
        drive_ab(1, BASE + 32'h4, 32'h11, 4'hF);
        drive_ab(1, BASE + 32'h8, 32'h22, 4'hF);
        drive_ab(1, BASE + 32'hC, 32'h33, 4'hF);
        drive_ab(0, BASE + 32'h4, 32'h0, 4'hF);
        drive_ab(0, BASE + 32'h8, 32'h0, 4'hF);
        drive_ab(0, BASE + 32'hC, 32'h0, 4'hF);
        req_ab = 0;
        chk("t4 rvalid_b 1st", 32'(rvalid_b), 1);
        chk("t4 rdata_b 1st", rdata_b, 32'h11);
        chk("t4 rdata_a 3rd", rdata_a, 32'h33);
        step();
        chk("t4 rdata_b 2nd", rdata_b, 32'h22);
        step();
        chk("t4 rdata_b 3rd", rdata_b, 32'h33);
        step();

        // Test 5: two grant-wait transactions with req held high.
        req_c = 1; we_c = 1; addr_c = BASE + 32'h14; wdata_c = 32'h55AA; be_c = 4'hF;
        chk("t5 gnt r+0", 32'(gnt_c), 0);
        step();
        chk("t5 gnt r+1", 32'(gnt_c), 0);
        step();
        chk("t5 gnt r+2", 32'(gnt_c), 1);
        step();
        we_c = 0; wdata_c = 0;
        chk("t5 gnt r+3", 32'(gnt_c), 0);
        step();
        chk("t5 gnt r+4", 32'(gnt_c), 1);
        chk("t5 wr rvalid", 32'(rvalid_c), 1);
        chk("t5 wr rdata", rdata_c, 32'h0);
        step();
        req_c = 0;
        chk("t5 gap rvalid", 32'(rvalid_c), 0);
        step();
        chk("t5 rd rvalid", 32'(rvalid_c), 1);
        chk("t5 rd rdata", rdata_c, 32'h55AA);
        // req dropped during the wait: no grant may follow
        req_c = 1;
        step();
        req_c = 0;
        repeat (3) step();

        fork
            rand_ab();
            rand_c();
        join
        repeat (5) step();

        // Test 6: reset with reads in flight on dut_b.
        drive_ab(1, BASE + 32'h1C, 32'h1234, 4'hF);
        drive_ab(0, BASE + 32'h1C, 32'h0, 4'hF);
        drive_ab(0, BASE + 32'h1C, 32'h0, 4'hF);
        req_ab = 0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        drive_ab(0, BASE + 32'h1C, 32'h0, 4'hF);
        req_ab = 0;
        chk("t6 rvalid_a", 32'(rvalid_a), 1);
        chk("t6 rdata_a", rdata_a, 32'h0);
        repeat (2) step();
        chk("t6 rdata_b", rdata_b, 32'h0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/obi_sbr_scratchpad.md
Name: obi_sbr_scratchpad

Overview:
- OBI subordinate (responder) serving a flop-based word scratchpad in the user domain.
- Serves as the target the edge-detection accelerator's manager port reads source pixels from and writes results to. Also serves as a standalone test target for the user manager path.
- Grants requests with optional wait states, returns in-order responses after a fixed latency, and flags out-of-range accesses with an error response.

Parameters:
- NumWords, 64, number of 32-bit words stored (power of two, ≥2)
- BaseAddr, 32'h2000_0000, byte address of word 0 (NumWords*4 aligned)
- ReadLatency, 1, cycles from grant handshake to rvalid (1..3)
- GntWaitCycles, 0, cycles req must be held before gnt is given (0..7)
- ErrData, 32'hBADCAB1E, rdata returned on out-of-range access

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_sbr_req_i  in  1  request valid
- obi_sbr_we_i  in  1  1 = write, 0 = read
- obi_sbr_addr_i  in  32  byte address
- obi_sbr_wdata_i  in  32  write data
- obi_sbr_be_i  in  4  byte enables
- obi_sbr_gnt_o  out  1  request accepted this cycle
- obi_sbr_rvalid_o  out  1  response valid
- obi_sbr_rdata_o  out  32  read data, or ErrData on error, or 0 for a good write
- obi_sbr_err_o  out  1  response error, qualified by rvalid

Interface decision: one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. All memory words are 0, the wait counter is 0, and the response pipeline is empty.
- Handshake: a transaction is accepted in the cycle where req_i && gnt_o. The manager holds req, we, addr, wdata and be stable until granted; that stability is not checked.
- Grant FSM, GntWaitCycles=0: gnt_o = req_i combinationally, so back-to-back accepts occur every cycle.
- Grant FSM, GntWaitCycles=N>0, states IDLE/WAIT/GRANT:
  - IDLE→WAIT when req_i=1, loading the counter with N-1.
  - WAIT decrements the counter; at 0 it goes to GRANT.
  - GRANT drives gnt_o=1 for one cycle, then returns to IDLE.
  - The first grant therefore lands N cycles after req rises. Each subsequent transaction waits N cycles again.
  - If req_i drops while in WAIT (protocol violation), return to IDLE without a grant.
- Range check: in range iff BaseAddr ≤ addr < BaseAddr+NumWords*4. Index = addr[2 +: log2(NumWords)]. addr[1:0] is ignored.
- Write, in range: at the accept edge, each byte lane i with be[i]=1 is updated. be=4'b0000 leaves memory unchanged but still produces a response.
- Read, in range: data is sampled at the accept edge.
  - A write accepted in cycle t is visible to a read accepted in cycle t+1.
  - A read at the same address in the same cycle is impossible (one accept per cycle).
- Out of range: no memory update. Response carries err=1 and rdata=ErrData for both reads and writes.
- Response pipeline: a ReadLatency-deep shift register of {valid, err, data}.
  - rvalid_o is asserted exactly ReadLatency cycles after the accept cycle (ReadLatency=1 means the cycle after the accept).
  - Responses are in order, one per accepted transaction. There is no response back-pressure.
  - Up to ReadLatency transactions are outstanding at once.
  - A good write returns rdata=0, err=0.
- Output holding: rdata_o and err_o hold their last value when rvalid_o=0. Verification checks them only when rvalid=1.
- Reset mid-operation: in-flight responses are dropped, the FSM goes to IDLE, and memory is cleared.

Decomposition:
- user_pkg holds:
  - the ScratchpadBase and ScratchpadWords constants;
  - the address-map rule entry added to user_addr_map / user_mgr_addr_map;
  - the new index enum entry alongside the other demux subordinates.
- Sub-module obi_rsp_pipe: a parameterised-depth valid/err/data shift register, also reusable by other user-domain responders.
- The storage array and grant FSM stay in the top.

Test Plan:
1. Reset, then read BaseAddr+0x10 with GntWaitCycles=0, ReadLatency=1 → gnt in the same cycle; rvalid the next cycle with rdata=0, err=0.
2. Write 0xDEADBEEF to BaseAddr+0x4 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read back-to-back → read returns 0xDEADBEAA. The read is accepted the cycle after the second write.
3. Read BaseAddr+NumWords*4 (first invalid), then write BaseAddr-4 → both responses have err=1, rdata=0xBADCAB1E. A follow-up read of word 0 returns 0, proving memory is untouched.
4. With ReadLatency=3, issue 3 consecutive reads of words 1,2,3 preloaded with 0x11,0x22,0x33 → rvalid on cycles accept+3 for each, in order 0x11, 0x22, 0x33.
5. With GntWaitCycles=2 and req held high for two transactions → gnt pulses 2 cycles after req rises and again 2 cycles after the previous gnt. Exactly two rvalids follow.
6. Pulse rst_ni low while 2 reads are in flight (ReadLatency=3) → no rvalid after reset deasserts, and a subsequent read of the written word returns 0.
